mmio_uart_tx: RTL and testbench

//  Memory-mapped 8N1 UART transmitter on the processor data port, downstream of the CPU.
//  It consumes WE / address_to_mem / data_to_mem and supplies read data for the top-level

---
 rtl/mmio_uart_tx_pkg.sv | 22 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and TX FSM state encodings.
package mmio_uart_tx_pkg;

    // Word offsets within the 16-byte register window (address_to_mem[3:2])
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    // STATUS register bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    // TX FSM state encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Ports: clk, reset (async active-low), push/din, pop/dout (head, comb), full, empty, count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    // Storage is cleared on reset so the head never reads X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + ONE;
            end
            if (do_pop) begin
                rptr <= rptr + ONE;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Ports: clk, reset (async active-low), WE/address_to_mem/data_to_mem (CPU store),
// sel + rd_data (comb read path), tx (serial line, idle high).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    off;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [15:0]   baudcnt;
    logic [7:0]    shift_reg;
    logic [15:0]   div;
    logic          ovf;
    logic          busy;
    logic          bit_end;
    logic [31:0]   status_word;
    logic          unused_ok;

    assign sel   = (address_to_mem[31:4] == BASE_ADDR[31:4]);
    assign off   = address_to_mem[3:2];
    assign wr_en = WE && sel;
    assign push  = wr_en && (off == REG_TXDATA);
    assign busy  = (state != S_IDLE);

    // Live compare against div: a smaller div written mid-bit is
    // caught when the 16-bit counter wraps round to it.
    assign bit_end = (baudcnt == div);

    // Pop from IDLE, or on the last STOP cycle for back-to-back frames.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    assign unused_ok = ^{address_to_mem[1:0], data_to_mem[31:16], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (data_to_mem[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= DEFAULT_DIV;
            ovf <= 1'b0;
        end else begin
            if (wr_en && (off == REG_DIV)) begin
                div <= data_to_mem[15:0];
            end
            if (push && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_en && (off == REG_STATUS) && data_to_mem[ST_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bitcnt    <= '0;
            baudcnt   <= '0;
            shift_reg <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_dout;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bitcnt <= '0;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        bitcnt    <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_reg <= fifo_dout;
                            state     <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (state == S_IDLE || bit_end) begin
                baudcnt <= '0;
            end else begin
                baudcnt <= baudcnt + 16'd1;
            end
        end
    end

    // tx decodes straight from state, so an async reset idles the line at once.
    always_comb begin
        tx = 1'b1;
        unique case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        status_word           = '0;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_BUSY]  = busy;
        status_word[ST_OVF]   = ovf;
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            unique case (off)
                REG_STATUS: rd_data = status_word;
                REG_DIV:    rd_data = {16'd0, div};
                default:    rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed + randomized bench for mmio_uart_tx against a
// frame-timeline model of the FIFO and transmitter.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] address_to_mem = '0;
    logic [31:0] data_to_mem = '0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .WE             (WE),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .sel            (sel),
        .rd_data        (rd_data),
        .tx             (tx)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line recorder, one sample per cycle
    bit rec = 1'b0;
    bit line[$];
    always @(negedge clk) if (rec) line.push_back(tx);

    // Reference model: each accepted byte gets a pop edge; a frame
    // occupies the FSM for 10*(div+1) edges from its pop edge.
    int          pop_e[$];
    logic [7:0]  exp_bytes[$];
    int          mdiv;
    bit          movf;

    function automatic int flen();
        return 10 * (mdiv + 1);
    endfunction

    function automatic int occ(int t);
        int o = 0;
        foreach (pop_e[k]) if (pop_e[k] > t) o++;
        return o;
    endfunction

    function automatic logic [31:0] exp_status(int t);
        int o = occ(t);
        bit b = 1'b0;
        foreach (pop_e[k]) begin
            if (pop_e[k] <= t && t < pop_e[k] + flen()) b = 1'b1;
        end
        return {28'd0, movf, b, (o == 0), (o == DEPTH)};
    endfunction

    task automatic model_reset();
        pop_e.delete();
        exp_bytes.delete();
        mdiv = 433;
        movf = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] b, input int t);
        int p;
        if (occ(t) < DEPTH) begin
            p = t + 1;
            if (pop_e.size() > 0 && pop_e[$] + flen() > p) p = pop_e[$] + flen();
            pop_e.push_back(p);
            exp_bytes.push_back(b);
        end else begin
            movf = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1;
        address_to_mem = BASE | {28'd0, r, 2'b00};
        data_to_mem = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
        data_to_mem = $urandom();
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        address_to_mem = BASE | {28'd0, r, 2'b00};
        #1;
        v = rd_data;
    endtask

    task automatic put(input logic [7:0] b);
        bus_wr(2'd0, {24'd0, b});
        model_push(b, cyc);
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_wr(2'd2, {$urandom_range(0, 65535), d});
        mdiv = d;
        pop_e.delete();
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        rd(2'd1, v);
        chk(tag, v, exp_status(cyc));
    endtask

    // Single frame into an idle transmitter, checked cycle by cycle
    task automatic frame_check(input logic [7:0] b);
        int i;
        logic e;
        put(b);
        chk("tx_idle_at_write", tx, 1'b1);
        for (int k = 0; k < flen(); k++) begin
            @(posedge clk);
            #1;
            i = k / (mdiv + 1);
            e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            chk($sformatf("tx_b%0d_div%0d", i, mdiv), tx, e);
        end
        @(posedge clk);
        #1;
        check_status("status_after_frame");
    endtask

    initial begin
        logic [31:0] v;
        int s;
        int n;
        logic [7:0] got;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1'b1);
        rd(2'd1, v);
        chk("reset_status", v, 32'h2);
        rd(2'd2, v);
        chk("reset_div", v, 32'd433);
        rd(2'd3, v);
        chk("unmapped_rd", v, 32'd0);
        rd(2'd0, v);
        chk("txdata_rd", v, 32'd0);
        address_to_mem = BASE + 32'h10;
        #1;
        chk("sel_outside", sel, 1'b0);
        chk("rd_outside", rd_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic frame at DIV=3, then random bytes and divisors
        set_div(16'd3);
        rd(2'd2, v);
        chk("div_rd", v, 32'd3);
        frame_check(8'h55);
        repeat (3) begin
            set_div(16'($urandom_range(0, 4)));
            frame_check(8'($urandom()));
        end

        // Burst of 9 at DIV=0, overflow, ovf clear, push+pop while full
        set_div(16'd0);
        exp_bytes.delete();
        line.delete();
        rec = 1'b1;
        for (int k = 0; k < 9; k++) put(8'($urandom()));
        check_status("status_after_9");
        put(8'($urandom()));
        check_status("status_ovf");
        bus_wr(2'd1, 32'h8);
        movf = 1'b0;
        check_status("status_ovf_clr");
        put(8'($urandom()));
        check_status("status_push_pop_full");
        repeat (110) @(posedge clk);
        #1;
        rec = 1'b0;
        check_status("status_drained");

        s = 0;
        while (s < line.size() && line[s] == 1'b1) s++;
        chk("burst_latency", s, 2);
        n = exp_bytes.size();
        chk("burst_count", n, 10);
        if (line.size() < s + 10 * n + 1) begin
            chk("line_length", line.size(), s + 10 * n + 1);
        end else begin
            for (int f = 0; f < n; f++) begin
                chk($sformatf("start_f%0d", f), line[s + 10 * f], 1'b0);
                got = '0;
                for (int b = 0; b < 8; b++) got[b] = line[s + 10 * f + 1 + b];
                chk($sformatf("byte_f%0d", f), got, exp_bytes[f]);
                chk($sformatf("stop_f%0d", f), line[s + 10 * f + 9], 1'b1);
            end
            chk("idle_after_burst", line[s + 10 * n], 1'b1);
        end

        // Reset in the middle of DATA with a second byte queued
        set_div(16'd3);
        put(8'h00);
        put(8'hA5);
        repeat (8) @(posedge clk);
        #2;
        chk("tx_mid_data", tx, 1'b0);
        reset = 1'b0;
        #1;
        chk("tx_async_reset", tx, 1'b1);
        rd(2'd1, v);
        chk("status_in_reset", v, 32'h2);
        rd(2'd2, v);
        chk("div_in_reset", v, 32'd433);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        set_div(16'd2);
        frame_check(8'($urandom()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
